// File: rtl/pref_fetch_ctrl.sv
// pref_fetch_ctrl: fetch sequencer for the prefetch word buffer that feeds the
// compressed-instruction aligner. Issues word-aligned fetches via the MMU and
// icache, keeps the buffer topped up, restarts on redirect, and discards any
// icache response that belongs to a request issued before a redirect.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   redirect_i/_pc_i  flush the stream and restart at a halfword-aligned PC
//   mmu_req_o         translation request (held while in REQ)
//   mmu_vaddr_o       word-aligned fetch virtual address
//   mmu_hit_i         translation valid this cycle
//   icache_req_o      mmu_req_o & mmu_hit_i
//   icache_ack_i      icache response valid
//   fill_we_o         buffer push strobe, same cycle as the accepted ack
//   buf_pop_i         consumer retired one buffer word
//   buf_count_o       valid words in the buffer
//   buf_empty_o/full  occupancy flags
//   start_misalign_o  first instruction after redirect starts at halfword 1
//   busy_o            sequencer not idle
//
// Build option PREF_FETCH_PERF_EN adds saturating performance counters
// stall_cnt_o, drop_cnt_o and empty_cnt_o (cleared by reset only).
module pref_fetch_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             mmu_req_o,
  output logic [XLEN-1:0]  mmu_vaddr_o,
  input  logic             mmu_hit_i,
  output logic             icache_req_o,
  input  logic             icache_ack_i,
  output logic             fill_we_o,
  input  logic             buf_pop_i,
  output logic [CNT_W-1:0] buf_count_o,
  output logic             buf_empty_o,
  output logic             buf_full_o,
  output logic             start_misalign_o,
  output logic             busy_o
`ifdef PREF_FETCH_PERF_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      drop_cnt_o,
  output logic [31:0]      empty_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              issued_q, issued_d;
  logic              misalign_q, misalign_d;

  logic              mmu_req;
  logic              icache_req;
  logic              fill_we;
  logic              pop_ok;
  logic [CNT_W-1:0]  count_nxt;
  logic              below_depth;

  // Halfword alignment makes bit 0 of the redirect PC meaningless here.
  logic unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc_i[0];

  // Next-state, occupancy and fetch address computation.
  always_comb begin
    mmu_req     = (state_q == ST_REQ);
    icache_req  = mmu_req & mmu_hit_i;
    fill_we     = mmu_req & icache_ack_i & ~redirect_i;
    pop_ok      = buf_pop_i & (count_q != '0);
    count_nxt   = count_q + CNT_W'(fill_we) - CNT_W'(pop_ok);
    below_depth = (count_nxt < CNT_W'(BUF_DEPTH));

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_nxt;
    misalign_d = misalign_q;

    if (fill_we) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    unique case (state_q)
      ST_IDLE:  if (below_depth) state_d = ST_REQ;
      ST_REQ:   if (icache_ack_i && !below_depth) state_d = ST_IDLE;
      ST_DRAIN: if (icache_ack_i) state_d = ST_REQ;
      default:  state_d = ST_IDLE;
    endcase

    if (redirect_i) begin
      count_d    = '0;
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      misalign_d = redirect_pc_i[1];
      if (state_q == ST_DRAIN) begin
        // An ack arriving with the redirect retires the stale response.
        state_d = icache_ack_i ? ST_REQ : ST_DRAIN;
      end else if ((state_q == ST_REQ) && (issued_q || icache_req) && !icache_ack_i) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_REQ;
      end
    end

    // A request is outstanding from the cycle it is presented until its ack.
    if ((state_d != ST_REQ) || icache_ack_i) begin
      issued_d = 1'b0;
    end else if (icache_req) begin
      issued_d = 1'b1;
    end else begin
      issued_d = issued_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      count_q    <= '0;
      issued_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      misalign_q <= misalign_d;
    end
  end

  assign mmu_req_o        = mmu_req;
  assign mmu_vaddr_o      = fetch_pc_q;
  assign icache_req_o     = icache_req;
  assign fill_we_o        = fill_we;
  assign buf_count_o      = count_q;
  assign buf_empty_o      = (count_q == '0);
  assign buf_full_o       = (count_q == CNT_W'(BUF_DEPTH));
  assign start_misalign_o = misalign_q;
  assign busy_o           = (state_q != ST_IDLE);

`ifdef PREF_FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] empty_cnt_q, empty_cnt_d;
  logic        drop_evt;

  // Saturating event counters.
  always_comb begin
    drop_evt    = icache_ack_i & ((state_q == ST_DRAIN) | ((state_q == ST_REQ) & redirect_i));
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    empty_cnt_d = empty_cnt_q;
    if (mmu_req && !icache_ack_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (drop_evt && (drop_cnt_q != '1))                  drop_cnt_d  = drop_cnt_q + 32'd1;
    if ((count_q == '0) && (state_q == ST_IDLE) && (empty_cnt_q != '1))
      empty_cnt_d = empty_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
      empty_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign empty_cnt_o = empty_cnt_q;
`endif

endmodule
